// File: rtl/booth_mult_seq_ctrl.sv
// booth_mult_seq_ctrl
//
// Sequential radix-4 Modified Booth multiplier. One shared carry-lookahead adder,
// DATA_WIDTH+2 bits wide, does all of the arithmetic. It first forms -M, then
// accumulates one partial product per Booth digit of Q, two bits per cycle.
//
// Ports:
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_valid/o_ready  operand handshake. o_ready is high only while idle.
//   i_multiplicand   signed multiplicand M
//   i_multiplier     signed multiplier Q
//   o_valid/i_ready  product handshake. The product is held while i_ready is low.
//   o_product        signed 2*DATA_WIDTH-bit product M*Q. Zero when not valid.
//   o_busy           high while -M is being formed or digits are being accumulated
//
// DATA_WIDTH must be even and at least 4.

module booth_mult_seq_ctrl #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [DATA_WIDTH-1:0]     i_multiplicand,
  input  logic [DATA_WIDTH-1:0]     i_multiplier,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [2*DATA_WIDTH-1:0]   o_product,
  output logic                      o_busy
);

  // Two guard bits hold the range of the accumulator, including +/-2M.
  localparam int unsigned AccW      = DATA_WIDTH + 2;
  localparam int unsigned NumDigits = DATA_WIDTH / 2;
  localparam int unsigned CntW      = $clog2(NumDigits);
  // The adder is built from 2-bit lookahead groups. AccW is always even.
  localparam int unsigned NumGroups = AccW / 2;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StNeg  = 2'd1;
  localparam logic [1:0] StCalc = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [CntW-1:0] LastCnt = CntW'(NumDigits - 1);

  logic [1:0]            state_q, state_d;
  logic [AccW-1:0]       m_ext_q, m_ext_d;
  logic [AccW-1:0]       neg_m_q, neg_m_d;
  logic [AccW-1:0]       a_q, a_d;
  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic                  qm1_q, qm1_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic [AccW-1:0]       add_a;
  logic [AccW-1:0]       add_b;
  logic [AccW-1:0]       add_sum;
  logic [2:0]            digit;

  // ---------------------------------------------------------------------------
  // Shared adder: carry lookahead across 2-bit groups. The carry-in is always
  // zero because -M is formed as ~M + 1 with the 1 on operand two. The carry
  // out of the top group is not needed, so it is not built.
  // ---------------------------------------------------------------------------
  logic [NumGroups-1:0] grp_c;

  assign grp_c[0] = 1'b0;

  for (genvar k = 0; k < NumGroups; k++) begin : g_cla
    logic g0, p0, p1, c_mid;

    assign g0    = add_a[2*k] & add_b[2*k];
    assign p0    = add_a[2*k] ^ add_b[2*k];
    assign p1    = add_a[2*k+1] ^ add_b[2*k+1];
    assign c_mid = g0 | (p0 & grp_c[k]);

    assign add_sum[2*k]   = p0 ^ grp_c[k];
    assign add_sum[2*k+1] = p1 ^ c_mid;

    if (k < NumGroups - 1) begin : g_carry
      logic g1;
      assign g1         = add_a[2*k+1] & add_b[2*k+1];
      assign grp_c[k+1] = g1 | (p1 & g0) | (p1 & p0 & grp_c[k]);
    end
  end

  // ---------------------------------------------------------------------------
  // Adder operand selection
  // ---------------------------------------------------------------------------
  assign digit = {q_q[1:0], qm1_q};

  always_comb begin
    add_a = a_q;
    add_b = '0;
    if (state_q == StNeg) begin
      add_a = ~m_ext_q;
      add_b = {{(AccW-1){1'b0}}, 1'b1};
    end else begin
      case (digit)
        3'b001, 3'b010: add_b = m_ext_q;
        3'b011:         add_b = {m_ext_q[AccW-2:0], 1'b0};
        3'b100:         add_b = {neg_m_q[AccW-2:0], 1'b0};
        3'b101, 3'b110: add_b = neg_m_q;
        default:        add_b = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    m_ext_d = m_ext_q;
    neg_m_d = neg_m_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          m_ext_d = {{2{i_multiplicand[DATA_WIDTH-1]}}, i_multiplicand};
          q_d     = i_multiplier;
          qm1_d   = 1'b0;
          a_d     = '0;
          cnt_d   = '0;
          state_d = StNeg;
        end
      end

      StNeg: begin
        neg_m_d = add_sum;
        state_d = StCalc;
      end

      StCalc: begin
        // {A, Q, q_m1} <= {sum, Q, q_m1} >>> 2
        a_d   = {{2{add_sum[AccW-1]}}, add_sum[AccW-1:2]};
        q_d   = {add_sum[1:0], q_q[DATA_WIDTH-1:2]};
        qm1_d = q_q[1];
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end

      StDone: begin
        if (i_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      m_ext_q <= '0;
      neg_m_q <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_ext_q <= m_ext_d;
      neg_m_q <= neg_m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_ready   = (state_q == StIdle);
    o_valid   = (state_q == StDone);
    o_busy    = (state_q == StNeg) || (state_q == StCalc);
    o_product = '0;
    if (state_q == StDone) begin
      // The low DATA_WIDTH bits of A are the upper half of the exact product.
      o_product = {a_q[DATA_WIDTH-1:0], q_q};
    end
  end

endmodule

// File: tb/tb_booth_mult_seq_ctrl.sv
module tb_booth_mult_seq_ctrl;

  localparam int NR = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        a_valid, a_ready, a_ovalid, a_iready, a_busy;
  logic [31:0] a_mcand, a_mplier;
  logic [63:0] a_product;

  // 8-bit instance
  logic        b_valid, b_ready, b_ovalid, b_iready, b_busy;
  logic [7:0]  b_mcand, b_mplier;
  logic [15:0] b_product;

  booth_mult_seq_ctrl #(.DATA_WIDTH(32)) u_dut32 (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_valid        (a_valid),
    .o_ready        (a_ready),
    .i_multiplicand (a_mcand),
    .i_multiplier   (a_mplier),
    .o_valid        (a_ovalid),
    .i_ready        (a_iready),
    .o_product      (a_product),
    .o_busy         (a_busy)
  );

  booth_mult_seq_ctrl #(.DATA_WIDTH(8)) u_dut8 (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_valid        (b_valid),
    .o_ready        (b_ready),
    .i_multiplicand (b_mcand),
    .i_multiplier   (b_mplier),
    .o_valid        (b_ovalid),
    .i_ready        (b_iready),
    .o_product      (b_product),
    .o_busy         (b_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp_q32[$];
  logic [15:0] exp_q8[$];

  typedef struct {
    logic [31:0] m;
    logic [31:0] q;
    logic [63:0] p;
    string       name;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: no response within the cycle budget", name);
  endtask

  // Reference products: plain signed arithmetic on sign-extended operands.
  function automatic logic [63:0] ref32(input logic [31:0] m, input logic [31:0] q);
    logic signed [63:0] ms, qs;
    ms = {{32{m[31]}}, m};
    qs = {{32{q[31]}}, q};
    return ms * qs;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] m, input logic [7:0] q);
    logic signed [15:0] ms, qs;
    ms = {{8{m[7]}}, m};
    qs = {{8{q[7]}}, q};
    return ms * qs;
  endfunction

  // Issue one operation on the 32-bit instance and wait for o_valid.
  // lat = clock edges after the accept edge until o_valid is seen.
  task automatic run_op32(input logic [31:0] m, input logic [31:0] q,
                          output logic [63:0] prod, output int lat, output int busy_n,
                          output bit ok);
    int w;
    w = 0;
    ok = 1'b0;
    prod = '0;
    lat = 0;
    busy_n = 0;
    while (!a_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!a_ready) begin
      fail_now("ready_wait32");
      return;
    end
    a_mcand  = m;
    a_mplier = q;
    a_valid  = 1'b1;
    @(negedge clk);
    a_valid  = 1'b0;
    a_mcand  = $urandom;
    a_mplier = $urandom;
    for (int i = 0; i < 100; i++) begin
      if (a_busy) busy_n++;
      if (a_ovalid) break;
      @(negedge clk);
      lat++;
    end
    if (!a_ovalid) begin
      fail_now("valid_wait32");
      return;
    end
    prod = a_product;
    ok = 1'b1;
  endtask

  // Complete the output handshake; o_ready must be back one cycle later.
  task automatic drain32(input string name);
    a_iready = 1'b1;
    @(negedge clk);
    a_iready = 1'b0;
    check({name, "_ready_after"}, 64'(a_ready), 64'd1);
    check({name, "_valid_after"}, 64'(a_ovalid), 64'd0);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [63:0] prod, held;
    int lat, busy_n;
    bit ok;

    a_valid = 0; a_iready = 0; a_mcand = '0; a_mplier = '0;
    b_valid = 0; b_iready = 0; b_mcand = '0; b_mplier = '0;

    vecs[0] = '{32'd7,        32'd6,        64'h00000000_0000002A, "7x6"};
    vecs[1] = '{32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1, "m3x5"};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, "m1xm1"};
    vecs[3] = '{32'h80000000, 32'h80000000, 64'h40000000_00000000, "minxmin"};
    vecs[4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, "maxxmax"};
    vecs[5] = '{32'h80000000, 32'h7FFFFFFF, 64'hC0000000_80000000, "minxmax"};

    // Reset values
    #2;
    check("rst_ready",   64'(a_ready),  64'd1);
    check("rst_valid",   64'(a_ovalid), 64'd0);
    check("rst_product", a_product,     64'd0);
    check("rst_busy",    64'(a_busy),   64'd0);
    check("rst_ready8",  64'(b_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven directed vectors
    for (int i = 0; i < 6; i++) begin
      run_op32(vecs[i].m, vecs[i].q, prod, lat, busy_n, ok);
      if (ok) begin
        check({vecs[i].name, "_product"}, prod, vecs[i].p);
        // o_valid rises DATA_WIDTH/2+1 edges after the accept edge
        check({vecs[i].name, "_latency"}, 64'(lat), 64'd17);
        if (i == 0) check("7x6_busy_cycles", 64'(busy_n), 64'd17);
        drain32(vecs[i].name);
      end
    end

    // Backpressure: product held, o_ready low, stray i_valid ignored
    run_op32(32'h00001234, 32'hFFFFFFF9, prod, lat, busy_n, ok);
    if (ok) begin
      check("bp_product", prod, ref32(32'h00001234, 32'hFFFFFFF9));
      held = prod;
      for (int c = 0; c < 5; c++) begin
        if (c == 1) begin
          a_valid  = 1'b1;
          a_mcand  = 32'h0BADF00D;
          a_mplier = 32'h12345678;
        end
        @(negedge clk);
        a_valid = 1'b0;
        check("bp_hold_product", a_product,     held);
        check("bp_hold_valid",   64'(a_ovalid), 64'd1);
        check("bp_hold_ready",   64'(a_ready),  64'd0);
      end
      drain32("bp");
      repeat (3) @(negedge clk);
      check("bp_no_stray_op", 64'(a_busy), 64'd0);
    end

    // Asynchronous reset in the middle of the digit loop (cnt = 8)
    a_mcand  = 32'h13579BDF;
    a_mplier = 32'h2468ACE0;
    a_valid  = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check("midrst_busy_before", 64'(a_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_ready",   64'(a_ready),  64'd1);
    check("midrst_valid",   64'(a_ovalid), 64'd0);
    check("midrst_product", a_product,     64'd0);
    check("midrst_busy",    64'(a_busy),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op32(32'h000012FC, 32'h75CA0112, prod, lat, busy_n, ok);
    if (ok) begin
      check("postrst_product", prod, 64'h000008BC_26EC51B8);
      check("postrst_latency", 64'(lat), 64'd17);
      drain32("postrst");
    end

    // Randomized traffic on both widths, scoreboarded in order
    fork
      begin : prod32
        int gap, w;
        logic [31:0] m, q;
        for (int i = 0; i < NR; i++) begin
          gap = $urandom_range(0, 3);
          repeat (gap) @(negedge clk);
          m = $urandom;
          q = $urandom;
          if ($urandom_range(0, 15) == 0) m = 32'h80000000;
          if ($urandom_range(0, 15) == 0) q = 32'h80000000;
          if ($urandom_range(0, 15) == 0) q = 32'h7FFFFFFF;
          a_mcand = m; a_mplier = q; a_valid = 1'b1;
          w = 0;
          while (!a_ready && w < 200) begin
            @(negedge clk);
            w++;
          end
          if (!a_ready) begin
            fail_now("rand32_accept");
            a_valid = 1'b0;
            break;
          end
          @(negedge clk);
          exp_q32.push_back(ref32(m, q));
          a_valid = 1'b0;
        end
      end
      begin : cons32
        int got, cyc;
        got = 0;
        cyc = 0;
        while (got < NR && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          a_iready = ($urandom_range(0, 3) != 0);
          if (a_ovalid && a_iready) begin
            if (exp_q32.size() == 0) begin
              fail_now("rand32_unexpected_product");
            end else begin
              check("rand32", a_product, exp_q32.pop_front());
            end
            got++;
          end
        end
        a_iready = 1'b0;
        if (got < NR) fail_now("rand32_results");
      end
      begin : prod8
        int gap, w;
        logic [7:0] m, q;
        for (int i = 0; i < NR; i++) begin
          gap = $urandom_range(0, 3);
          repeat (gap) @(negedge clk);
          m = 8'($urandom);
          q = 8'($urandom);
          b_mcand = m; b_mplier = q; b_valid = 1'b1;
          w = 0;
          while (!b_ready && w < 200) begin
            @(negedge clk);
            w++;
          end
          if (!b_ready) begin
            fail_now("rand8_accept");
            b_valid = 1'b0;
            break;
          end
          @(negedge clk);
          exp_q8.push_back(ref8(m, q));
          b_valid = 1'b0;
        end
      end
      begin : cons8
        int got, cyc;
        got = 0;
        cyc = 0;
        while (got < NR && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          b_iready = ($urandom_range(0, 3) != 0);
          if (b_ovalid && b_iready) begin
            if (exp_q8.size() == 0) begin
              fail_now("rand8_unexpected_product");
            end else begin
              check("rand8", 64'(b_product), 64'(exp_q8.pop_front()));
            end
            got++;
          end
        end
        b_iready = 1'b0;
        if (got < NR) fail_now("rand8_results");
      end
    join

    check("rand32_leftover", 64'(exp_q32.size()), 64'd0);
    check("rand8_leftover",  64'(exp_q8.size()),  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
